// File: rtl/pwm_pkg.sv
// Shared PWM link constants and FSM state type; the period default must match the receiver.
// No logic: latency and backpressure are defined by the modules that import this package.
package pwm_pkg;

  localparam int CNT_W_DEF    = 10;
  localparam int PERIOD_DEF   = 512;
  localparam int PRESCALE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_t;

  // A divide-by-1 prescaler still needs a 1-bit register to keep the port widths legal.
  function automatic int ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM period counter: tick is combinational from the divider register.
// Held at 0 while run is low; no backpressure.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int              PS_W = ps_width(PRESCALE);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_cnt;
  logic            w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = run && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM transmitter: duty word -> registered pwm_out, 1 clk after the counter/duty update.
// One-deep duty slot; duty_ready drops while a value waits for the next period boundary.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERIOD   = PERIOD_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  pwm_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_duty;
  logic [CNT_W-1:0] r_pending_duty;
  logic             r_pending;
  logic             r_pwm;
  logic             r_period_start;
  logic             r_busy;

  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_duty_next;
  logic             w_run;
  logic             w_tick;
  logic             w_wrap;
  logic             w_start;
  logic             w_accept;
  logic             w_load;
  logic             w_high;

  assign w_run = (r_state != IDLE);

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (w_run),
    .tick (w_tick)
  );

  assign w_wrap   = w_tick && (r_cnt == CNT_LAST);
  assign w_start  = (r_state == IDLE) && enable;
  assign w_accept = duty_valid && !r_pending;
  assign w_load   = w_start || w_wrap;

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_run || w_wrap) begin
      w_cnt_next = '0;
    end else if (w_tick) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // A word accepted on the boundary cycle itself goes straight to the active duty.
  always_comb begin
    w_duty_next = r_active_duty;
    if (w_load) begin
      if (r_pending) begin
        w_duty_next = r_pending_duty;
      end else if (w_accept) begin
        w_duty_next = duty_in;
      end
    end
  end

  assign w_high = (w_cnt_next < w_duty_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_active_duty  <= '0;
      r_pending_duty <= '0;
      r_pending      <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_active_duty <= w_duty_next;
      if (w_load) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending      <= 1'b1;
        r_pending_duty <= duty_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_period_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state        <= RUN;
            r_pwm          <= w_high;
            r_busy         <= 1'b1;
            r_period_start <= 1'b1;
          end else begin
            r_pwm  <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          r_pwm          <= w_high;
          r_busy         <= 1'b1;
          r_period_start <= w_wrap;
          if (!enable) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Re-enabling mid-drain keeps the counter running, so the waveform never gaps.
          if (enable) begin
            r_state        <= RUN;
            r_pwm          <= w_high;
            r_period_start <= w_wrap;
          end else if (w_wrap) begin
            r_state <= IDLE;
            r_pwm   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_pwm <= w_high;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pwm   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign duty_ready   = !r_pending;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign busy         = r_busy;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed scenarios plus random duty/enable traffic,
// every cycle compared against a time-based model of the PWM link.
module tb_pwm_generator;

  localparam int PERIOD   = 512;
  localparam int PRESCALE = 4;
  localparam int PCLK     = PERIOD * PRESCALE;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       enable     = 1'b0;
  logic       duty_valid = 1'b0;
  logic [9:0] duty_in    = '0;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_start;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;

  // Model: m_t is clk cycles elapsed in the current period, m_drain means enable was low.
  bit m_on = 0, m_drain = 0, m_pv = 0, m_ps = 0;
  int m_t = 0, m_duty = 0, m_pd = 0;

  int cyc = 0, n_ps = 0, last_ps = 0, last_high = 0, last_interval = 0, hcnt = 0;

  always #5 clk = ~clk;

  pwm_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int take_duty(input bit acc);
    int d;
    d = m_duty;
    if (m_pv) begin
      d = m_pd;
      m_pv = 0;
    end else if (acc) begin
      d = int'(duty_in);
    end
    return d;
  endfunction

  initial forever begin
    bit acc, wrap;
    bit [3:0] exp_v;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      m_on = 0; m_drain = 0; m_pv = 0; m_ps = 0; m_t = 0; m_duty = 0; m_pd = 0;
    end
    exp_v = {m_on && ((m_t / PRESCALE) < m_duty), m_ps, m_on, !m_pv};
    chk("cycle", {pwm_out, period_start, busy, duty_ready}, exp_v);
    if (period_start) begin
      last_high     = hcnt;
      last_interval = cyc - last_ps;
      last_ps       = cyc;
      hcnt          = 0;
      n_ps++;
    end
    if (pwm_out) hcnt++;
    if (rst_n) begin
      acc  = duty_valid && !m_pv;
      m_ps = 0;
      if (!m_on) begin
        if (enable) begin
          m_on = 1; m_t = 0; m_drain = 0; m_ps = 1;
          m_duty = take_duty(acc);
        end else if (acc) begin
          m_pv = 1; m_pd = int'(duty_in);
        end
      end else begin
        wrap = (m_t == PCLK - 1);
        m_t  = wrap ? 0 : m_t + 1;
        if (wrap) begin
          m_duty = take_duty(acc);
          if (m_drain && !enable) m_on = 0;
          else m_ps = 1;
        end else if (acc) begin
          m_pv = 1; m_pd = int'(duty_in);
        end
        m_drain = m_on && !enable;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_duty(input int d, input string tag);
    int k;
    bit ok;
    k  = 0;
    ok = 0;
    duty_in    = 10'(d);
    duty_valid = 1'b1;
    while (!ok && k < 3 * PCLK) begin
      @(negedge clk);
      ok = duty_ready;
      @(posedge clk);
      #1;
      k++;
    end
    duty_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(ok), 1);
  endtask

  task automatic wait_ps(input string tag);
    int n0;
    int k;
    n0 = n_ps;
    k  = 0;
    while (n_ps == n0 && k < 2 * PCLK + 16) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({tag, "_seen"}, 32'(n_ps != n0), 1);
  endtask

  initial begin
    int n0;
    int k;
    step(3);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", duty_ready, 1);
    chk("rst_ps", period_start, 0);
    rst_n = 1'b1;
    step(2);

    // Steady PWM, with the first duty loaded while idle
    send_duty(128, "t2_send");
    chk("t2_idle_hold", duty_ready, 0);
    step(5);
    enable = 1'b1;
    wait_ps("t2_start");
    wait_ps("t2_p1");
    chk("t2_interval", last_interval, PCLK);
    chk("t2_high", last_high, 512);

    // Boundary update
    step(600);
    send_duty(384, "t3_send");
    chk("t3_ready_low", duty_ready, 0);
    wait_ps("t3_wrap");
    chk("t3_ready_back", duty_ready, 1);
    chk("t3_old_high", last_high, 512);
    wait_ps("t3_next");
    chk("t3_high", last_high, 1536);

    // Bypass on the exact wrap cycle
    step(2046);
    duty_in    = 10'd64;
    duty_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready_at_wrap", duty_ready, 1);
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
    @(negedge clk);
    chk("t6_ps", period_start, 1);
    chk("t6_ready", duty_ready, 1);
    wait_ps("t6_next");
    chk("t6_high", last_high, 256);

    // Extremes
    send_duty(0, "t4_zero_send");
    wait_ps("t4_zero_load");
    wait_ps("t4_zero_end");
    chk("t4_zero_high", last_high, 0);
    send_duty(600, "t4_full_send");
    wait_ps("t4_full_load");
    for (int i = 0; i < 3; i++) begin
      wait_ps("t4_full_wrap");
      chk("t4_full_high", last_high, PCLK);
      chk("t4_full_interval", last_interval, PCLK);
    end

    // Disable at cnt=100 drains the period
    send_duty(300, "t5_send");
    wait_ps("t5_load");
    step(399);
    enable = 1'b0;
    n0 = n_ps;
    k  = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 2 * PCLK);
    chk("t5_drain_len", k, PCLK - 400 + 1);
    chk("t5_idle_pwm", pwm_out, 0);
    chk("t5_no_ps", n_ps - n0, 0);
    step(50);
    chk("t5_still_idle", busy, 0);

    // Re-enable at cnt=300 during the drain
    enable = 1'b1;
    wait_ps("t5_restart");
    step(399);
    enable = 1'b0;
    step(800);
    enable = 1'b1;
    wait_ps("t5_nogap");
    chk("t5_interval", last_interval, PCLK);
    chk("t5_high", last_high, 1200);

    // Async reset mid-period while the output is high
    step(10);
    chk("t1_pre_high", pwm_out, 1);
    #1;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("t1_pwm_async", pwm_out, 0);
    chk("t1_busy_async", busy, 0);
    step(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_ready", duty_ready, 1);
    step(2);
    enable = 1'b1;
    wait_ps("t1_start");
    wait_ps("t1_p1");
    chk("t1_duty_lost", last_high, 0);

    // Random duty words and enable drops
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          send_duty($urandom_range(0, 700), "rnd_send");
          step($urandom_range(1, 1000));
        end
        2: begin
          enable = 1'b0;
          step($urandom_range(1, 2500));
          enable = 1'b1;
          step($urandom_range(1, 500));
        end
        default: begin
          duty_in    = 10'($urandom_range(0, 1023));
          duty_valid = 1'b1;
          step($urandom_range(1, 4));
          duty_valid = 1'b0;
          step($urandom_range(1, 1000));
        end
      endcase
    end
    enable = 1'b0;
    step(3 * PCLK / 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
